// File: rtl/p_hit_div_if.sv
// p_hit_div_if
//   Operand and result bundle for the ray/plane hit-point stage.
//   The input side has the operand vectors and the empty/rd_en pop pair.
//   The output side has the hit point, the miss flag and the full/wr_en push pair.
//   Modports:
//     slave  - the hit-point stage
//     master - the FIFO side that feeds the stage and takes its results
//   Every vector is 3 x DATA_WIDTH, packed as [2:0][DATA_WIDTH-1:0] (x, y, z = 0, 1, 2).
//   Each element is signed fixed point.
interface p_hit_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0][DATA_WIDTH-1:0] tri_normal;
  logic [2:0][DATA_WIDTH-1:0] v0;
  logic [2:0][DATA_WIDTH-1:0] origin;
  logic [2:0][DATA_WIDTH-1:0] dir;
  logic                       in_empty;
  logic                       in_rd_en;
  logic [2:0][DATA_WIDTH-1:0] p_hit;
  logic                       hit_miss;
  logic                       out_full;
  logic                       out_wr_en;

  modport slave (
    input  tri_normal, v0, origin, dir, in_empty, out_full,
    output in_rd_en, p_hit, hit_miss, out_wr_en
  );

  modport master (
    output tri_normal, v0, origin, dir, in_empty, out_full,
    input  in_rd_en, p_hit, hit_miss, out_wr_en
  );
endinterface

// File: rtl/p_hit_div_module.sv
// p_hit_div_module
//   Ray/plane hit-point stage. The stage handles one ray at a time:
//     t     = n.(v0 - origin) / (n.dir)
//     p_hit = origin + t*dir
//   All values are signed fixed point with Q_BITS fractional bits.
//   A built-in restoring divider produces one quotient bit per clock.
//   Ports:
//     clock - rising-edge clock
//     reset - synchronous, active-high
//     bus   - p_hit_div_if.slave
//             operands with in_empty/in_rd_en
//             results with out_full/out_wr_en
//   Build option:
//     P_HIT_CULL_EN - when defined, a negative t (plane behind the ray origin)
//                     is also reported as a miss.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | wait for operands; pop and latch them when the FIFO is not empty
//   DOT   | fixed-point dot products; den==0 goes straight to OUT as a miss
//   DIV   | restoring divide, DATA_WIDTH+Q_BITS cycles via a down-counter
//   MUL   | saturate t, form origin + t*dir, register the result
//   OUT   | hold result; push when the output FIFO has room
module p_hit_div_module #(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10
) (
  input  logic         clock,
  input  logic         reset,
  p_hit_div_if.slave   bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int DQW = DATA_WIDTH + Q_BITS;
  localparam int CW  = $clog2(DQW);

  localparam logic [DW-1:0] T_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] T_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_DOT, ST_DIV, ST_MUL, ST_OUT} state_t;

  state_t state, state_nxt;

  logic [2:0][DW-1:0] n_r, v0_r, org_r, dir_r;
  logic [2:0][DW-1:0] p_hit_r;
  logic               miss_r;
  logic [DQW-1:0]     dq_r;       // dividend shifts out the top, quotient shifts in the bottom
  logic [DW-1:0]      rem_r;
  logic [DW-1:0]      den_abs_r;
  logic               neg_r;
  logic [CW-1:0]      cnt_r;

  logic               rd_en, wr_en;

  // Full-width signed product, floored by the fractional shift, then truncated.
  function automatic logic signed [DW-1:0] fx_mul(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] wa, wb;
    wa = a;
    wb = b;
    return DW'((wa * wb) >>> Q_BITS);
  endfunction

  logic signed [DW-1:0] dot_v0, dot_org, num, den;
  logic [DW-1:0]        num_abs, den_abs;

  always_comb begin
    dot_v0  = fx_mul(n_r[0], v0_r[0])  + fx_mul(n_r[1], v0_r[1])  + fx_mul(n_r[2], v0_r[2]);
    dot_org = fx_mul(n_r[0], org_r[0]) + fx_mul(n_r[1], org_r[1]) + fx_mul(n_r[2], org_r[2]);
    num     = dot_v0 - dot_org;
    den     = fx_mul(n_r[0], dir_r[0]) + fx_mul(n_r[1], dir_r[1]) + fx_mul(n_r[2], dir_r[2]);
    // Magnitudes are unsigned, so -(-2^(DW-1)) is represented correctly.
    num_abs = num[DW-1] ? -num : num;
    den_abs = den[DW-1] ? -den : den;
  end

  // The remainder always stays below the divisor (at most 2^(DW-1)).
  // One extra bit is therefore enough for the shifted trial value.
  logic [DW:0] rem_sh, rem_diff;
  logic        q_bit;

  always_comb begin
    rem_sh   = {rem_r, dq_r[DQW-1]};
    rem_diff = rem_sh - {1'b0, den_abs_r};
    q_bit    = ~rem_diff[DW];
  end

  logic signed [DW-1:0] t_sat;
  logic [2:0][DW-1:0]   p_mul;
  logic                 mul_miss;

  always_comb begin
    if (!neg_r) begin
      t_sat = (|dq_r[DQW-1:DW-1]) ? T_MAX : dq_r[DW-1:0];
    end else if ((|dq_r[DQW-1:DW]) || (dq_r[DW-1] && (|dq_r[DW-2:0]))) begin
      t_sat = T_MIN;
    end else begin
      t_sat = -dq_r[DW-1:0];
    end
    for (int i = 0; i < 3; i++) begin
      p_mul[i] = org_r[i] + fx_mul(t_sat, dir_r[i]);
    end
`ifdef P_HIT_CULL_EN
    mul_miss = t_sat[DW-1];
`else
    mul_miss = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_en = ~bus.in_empty & ~reset;
        if (rd_en) state_nxt = ST_DOT;
      end
      ST_DOT:  state_nxt = (den == '0) ? ST_OUT : ST_DIV;
      ST_DIV:  if (cnt_r == '0) state_nxt = ST_MUL;
      ST_MUL:  state_nxt = ST_OUT;
      ST_OUT: begin
        wr_en = ~bus.out_full & ~reset;
        if (wr_en) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_r       <= '0;
      v0_r      <= '0;
      org_r     <= '0;
      dir_r     <= '0;
      p_hit_r   <= '0;
      miss_r    <= 1'b0;
      dq_r      <= '0;
      rem_r     <= '0;
      den_abs_r <= '0;
      neg_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            n_r   <= bus.tri_normal;
            v0_r  <= bus.v0;
            org_r <= bus.origin;
            dir_r <= bus.dir;
          end
        end
        ST_DOT: begin
          dq_r      <= {num_abs, {Q_BITS{1'b0}}};
          rem_r     <= '0;
          den_abs_r <= den_abs;
          neg_r     <= num[DW-1] ^ den[DW-1];
          cnt_r     <= CW'(DQW - 1);
          if (den == '0) begin
            p_hit_r <= org_r;
            miss_r  <= 1'b1;
          end
        end
        ST_DIV: begin
          dq_r  <= {dq_r[DQW-2:0], q_bit};
          rem_r <= q_bit ? rem_diff[DW-1:0] : rem_sh[DW-1:0];
          if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
        end
        ST_MUL: begin
          p_hit_r <= mul_miss ? org_r : p_mul;
          miss_r  <= mul_miss;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_rd_en  = rd_en;
  assign bus.out_wr_en = wr_en;
  assign bus.p_hit     = p_hit_r;
  assign bus.hit_miss  = miss_r;
endmodule
